// File: rtl/spi_burst_tx.sv
// Peripheral-side burst SPI transmitter: valid/ready words shifted out MSB slice first over LINES data lines.
// Optional per-line even-parity beat after each word when SPI_TX_PARITY_EN is defined.
module spi_burst_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINES       = 4,
    parameter int DCLK_PERIOD = 100,
    parameter int CS_GAP      = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  last_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [LINES-1:0]      chip_data_out,
    output logic                  chip_clk_out,
    output logic                  chip_sel_out,
    output logic                  frame_last_out,
    output logic                  done_out,
    output logic                  busy_out
);

    localparam int BEATS = DATA_WIDTH / LINES;
    localparam int HALF  = DCLK_PERIOD / 2;
    localparam int CW    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int GW    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
`ifdef SPI_TX_PARITY_EN
    localparam int LAST_BEAT = BEATS;
`else
    localparam int LAST_BEAT = BEATS - 1;
`endif

    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [BW-1:0] DATA_END = BW'(BEATS - 1);
    localparam logic [BW-1:0] WORD_END = BW'(LAST_BEAT);
    localparam logic [GW-1:0] GAP_END  = GW'(CS_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [DATA_WIDTH-1:0]   hold_reg, hold_next;
    logic                    hold_last_reg, hold_last_next;
    logic                    hold_valid_reg, hold_valid_next;
    logic                    cur_last_reg, cur_last_next;
    logic [CW-1:0]           clk_count_reg, clk_count_next;
    logic [BW-1:0]           beat_reg, beat_next;
    logic [GW-1:0]           gap_count_reg, gap_count_next;
    logic                    dclk_reg, dclk_next;
    logic                    cs_reg, cs_next;
    logic [LINES-1:0]        data_reg, data_next;
    logic                    frame_last_reg, frame_last_next;
    logic                    done_reg, done_next;
`ifdef SPI_TX_PARITY_EN
    logic [LINES-1:0]        parity_reg, parity_next;
`endif

    logic                    accept;
    logic                    load_en;
    logic [DATA_WIDTH-1:0]   load_word;
    logic                    load_last;

    assign accept         = valid_in && !hold_valid_reg;
    assign ready_out      = !hold_valid_reg;
    assign chip_data_out  = data_reg;
    assign chip_clk_out   = dclk_reg;
    assign chip_sel_out   = cs_reg;
    assign frame_last_out = frame_last_reg;
    assign done_out       = done_reg;
    assign busy_out       = (state_reg != IDLE);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            hold_reg       <= '0;
            hold_last_reg  <= 1'b0;
            hold_valid_reg <= 1'b0;
            cur_last_reg   <= 1'b0;
            clk_count_reg  <= '0;
            beat_reg       <= '0;
            gap_count_reg  <= GAP_END;
            dclk_reg       <= 1'b0;
            cs_reg         <= 1'b1;
            data_reg       <= '0;
            frame_last_reg <= 1'b0;
            done_reg       <= 1'b0;
`ifdef SPI_TX_PARITY_EN
            parity_reg     <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            hold_reg       <= hold_next;
            hold_last_reg  <= hold_last_next;
            hold_valid_reg <= hold_valid_next;
            cur_last_reg   <= cur_last_next;
            clk_count_reg  <= clk_count_next;
            beat_reg       <= beat_next;
            gap_count_reg  <= gap_count_next;
            dclk_reg       <= dclk_next;
            cs_reg         <= cs_next;
            data_reg       <= data_next;
            frame_last_reg <= frame_last_next;
            done_reg       <= done_next;
`ifdef SPI_TX_PARITY_EN
            parity_reg     <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        hold_next       = hold_reg;
        hold_last_next  = hold_last_reg;
        hold_valid_next = hold_valid_reg;
        cur_last_next   = cur_last_reg;
        clk_count_next  = clk_count_reg;
        beat_next       = beat_reg;
        gap_count_next  = gap_count_reg;
        dclk_next       = dclk_reg;
        cs_next         = cs_reg;
        data_next       = data_reg;
        frame_last_next = frame_last_reg;
        done_next       = 1'b0;
        load_en         = 1'b0;
        load_word       = hold_reg;
        load_last       = hold_last_reg;
`ifdef SPI_TX_PARITY_EN
        parity_next     = parity_reg;
`endif

        case (state_reg)
            IDLE: begin
                // The gap counter keeps running while idle so a quick restart still honours CS_GAP.
                if (gap_count_reg != GAP_END) begin
                    gap_count_next = gap_count_reg + 1'b1;
                end
                if (accept) begin
                    if (gap_count_reg == GAP_END) begin
                        load_en   = 1'b1;
                        load_word = data_in;
                        load_last = last_in;
                    end else begin
                        hold_next       = data_in;
                        hold_last_next  = last_in;
                        hold_valid_next = 1'b1;
                        state_next      = GAP;
                    end
                end
            end

            SHIFT: begin
                if (accept) begin
                    hold_next       = data_in;
                    hold_last_next  = last_in;
                    hold_valid_next = 1'b1;
                end
                if (clk_count_reg != HALF_END) begin
                    clk_count_next = clk_count_reg + 1'b1;
                end else begin
                    clk_count_next = '0;
                    if (!dclk_reg) begin
                        dclk_next = 1'b1;
                    end else begin
                        dclk_next = 1'b0;
                        if (beat_reg != WORD_END) begin
                            beat_next = beat_reg + 1'b1;
`ifdef SPI_TX_PARITY_EN
                            if (beat_reg == DATA_END) begin
                                data_next = parity_reg;
                            end else begin
                                data_next   = shift_reg[DATA_WIDTH-1 -: LINES];
                                shift_next  = shift_reg << LINES;
                                parity_next = parity_reg ^ shift_reg[DATA_WIDTH-1 -: LINES];
                            end
`else
                            data_next  = shift_reg[DATA_WIDTH-1 -: LINES];
                            shift_next = shift_reg << LINES;
`endif
                        end else if (!cur_last_reg && hold_valid_reg) begin
                            load_en         = 1'b1;
                            hold_valid_next = 1'b0;
                        end else if (!cur_last_reg && valid_in) begin
                            // Hold is empty, so the word offered this cycle goes straight to the shifter.
                            load_en         = 1'b1;
                            load_word       = data_in;
                            load_last       = last_in;
                            hold_valid_next = 1'b0;
                        end else begin
                            cs_next         = 1'b1;
                            data_next       = '0;
                            frame_last_next = 1'b0;
                            done_next       = 1'b1;
                            beat_next       = '0;
                            gap_count_next  = '0;
                            state_next      = (hold_valid_reg || accept) ? GAP : IDLE;
                        end
                    end
                end
            end

            GAP: begin
                if (accept) begin
                    hold_next       = data_in;
                    hold_last_next  = last_in;
                    hold_valid_next = 1'b1;
                end
                if (gap_count_reg == GAP_END) begin
                    load_en         = 1'b1;
                    hold_valid_next = 1'b0;
                end else begin
                    gap_count_next = gap_count_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Common word start: first slice is driven with CS falling, DCLK low.
        if (load_en) begin
            state_next      = SHIFT;
            shift_next      = load_word << LINES;
            data_next       = load_word[DATA_WIDTH-1 -: LINES];
            clk_count_next  = '0;
            beat_next       = '0;
            dclk_next       = 1'b0;
            cs_next         = 1'b0;
            frame_last_next = load_last;
            cur_last_next   = load_last;
`ifdef SPI_TX_PARITY_EN
            parity_next     = load_word[DATA_WIDTH-1 -: LINES];
`endif
        end
    end

endmodule

// File: tb/tb_spi_burst_tx.sv
// Directed bench for spi_burst_tx (8-bit words, 4 lines, DCLK_PERIOD=4, CS_GAP=2).
// A negedge monitor records beats, CS run lengths and done pulses; tests compare deltas against hand values.
module tb_spi_burst_tx;

`ifdef SPI_TX_PARITY_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int WORD_CLKS = NB * 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       last;
    logic       valid;
    logic       ready;
    logic [3:0] cipo;
    logic       dclk;
    logic       cs;
    logic       frame_last;
    logic       done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] beats_q[$];
    logic       fl_q[$];
    int         low_q[$];
    int         high_q[$];
    int         done_cnt = 0;
    int         dclk_bad = 0;
    int         run = 0;
    logic       prev_cs = 1'b1;
    logic       prev_dclk = 1'b0;

    spi_burst_tx #(
        .DATA_WIDTH (8),
        .LINES      (4),
        .DCLK_PERIOD(4),
        .CS_GAP     (2)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .data_in       (data),
        .last_in       (last),
        .valid_in      (valid),
        .ready_out     (ready),
        .chip_data_out (cipo),
        .chip_clk_out  (dclk),
        .chip_sel_out  (cs),
        .frame_last_out(frame_last),
        .done_out      (done),
        .busy_out      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!cs && dclk && !prev_dclk) begin
            beats_q.push_back(cipo);
            fl_q.push_back(frame_last);
        end
        if (cs && dclk) dclk_bad <= dclk_bad + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (cs == prev_cs) begin
            run <= run + 1;
        end else begin
            if (prev_cs) high_q.push_back(run);
            else low_q.push_back(run);
            run <= 1;
        end
        prev_cs   <= cs;
        prev_dclk <= dclk;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] w, input logic l);
        bit ok;
        ok    = 1'b0;
        data  = w;
        last  = l;
        valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            $display("send data %02h last %0d accepted at %0t", w, l, $time);
        end else begin
            check("accept_timeout", 0, 1);
        end
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, int'(ok), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_word(input string tag, input int base, input logic [7:0] w, input logic fl);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = w[7:4];
        lo = w[3:0];
        check({tag, "_nbeats"}, int'(beats_q.size() >= base + NB), 1);
        if (beats_q.size() >= base + NB) begin
            check({tag, "_hi"}, int'(beats_q[base]), int'(hi));
            check({tag, "_lo"}, int'(beats_q[base + 1]), int'(lo));
            check({tag, "_fl0"}, int'(fl_q[base]), int'(fl));
            check({tag, "_fl1"}, int'(fl_q[base + 1]), int'(fl));
`ifdef SPI_TX_PARITY_EN
            check({tag, "_par"}, int'(beats_q[base + 2]), int'(hi ^ lo));
            check({tag, "_flp"}, int'(fl_q[base + 2]), int'(fl));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, l0, h0, d0;
        rst_n = 1'b0;
        data  = '0;
        last  = 1'b0;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", int'(cs), 1);
        check("rst_dclk", int'(dclk), 0);
        check("rst_data", int'(cipo), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fl", int'(frame_last), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;

        // 1: single last word from idle
        b0 = beats_q.size(); l0 = low_q.size(); d0 = done_cnt;
        send(8'hA5, 1'b1);
        wait_idle("t1");
        check("t1_cs_low", low_q[l0], WORD_CLKS);
        check_word("t1_w0", b0, 8'hA5, 1'b1);
        check("t1_done", done_cnt - d0, 1);
        check("t1_fl_idle", int'(frame_last), 0);
        check("t1_cs_idle", int'(cs), 1);

        // 2: three-word burst with valid held
        @(posedge clk); #1;
        b0 = beats_q.size(); l0 = low_q.size(); d0 = done_cnt;
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b1);
        wait_idle("t2");
        check("t2_cs_low", low_q[l0], 3 * WORD_CLKS);
        check_word("t2_w0", b0, 8'h12, 1'b0);
        check_word("t2_w1", b0 + NB, 8'h34, 1'b0);
        check_word("t2_w2", b0 + 2 * NB, 8'h56, 1'b1);
        check("t2_done", done_cnt - d0, 1);

        // 3: non-last word then nothing: underrun ends burst
        @(posedge clk); #1;
        b0 = beats_q.size(); l0 = low_q.size(); d0 = done_cnt;
        send(8'h77, 1'b0);
        wait_idle("t3");
        check("t3_cs_low", low_q[l0], WORD_CLKS);
        check_word("t3_w0", b0, 8'h77, 1'b0);
        check("t3_done", done_cnt - d0, 1);
        check("t3_ready", int'(ready), 1);

        // 4: last word with next word already in hold: CS high exactly CS_GAP clocks
        @(posedge clk); #1;
        b0 = beats_q.size(); l0 = low_q.size(); h0 = high_q.size(); d0 = done_cnt;
        send(8'hA1, 1'b1);
        send(8'hB2, 1'b1);
        wait_idle("t4");
        check("t4_cs_low0", low_q[l0], WORD_CLKS);
        check("t4_gap", high_q[h0 + 1], 2);
        check("t4_cs_low1", low_q[l0 + 1], WORD_CLKS);
        check_word("t4_w0", b0, 8'hA1, 1'b1);
        check_word("t4_w1", b0 + NB, 8'hB2, 1'b1);
        check("t4_done", done_cnt - d0, 2);

        // 5: reset during beat 1
        @(posedge clk); #1;
        d0 = done_cnt;
        send(8'hC3, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t5_beat1_data", int'(cipo), 3);
        check("t5_beat1_cs", int'(cs), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_cs", int'(cs), 1);
        check("t5_dclk", int'(dclk), 0);
        check("t5_data", int'(cipo), 0);
        check("t5_ready", int'(ready), 1);
        check("t5_busy", int'(busy), 0);
        check("t5_fl", int'(frame_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);

`ifdef SPI_TX_PARITY_EN
        // 6: parity beat on F3 -> F, 3, C
        @(posedge clk); #1;
        b0 = beats_q.size(); l0 = low_q.size();
        send(8'hF3, 1'b1);
        wait_idle("t6");
        check("t6_cs_low", low_q[l0], 12);
        check("t6_par_c", int'(beats_q[b0 + 2]), 12);
        check_word("t6_w0", b0, 8'hF3, 1'b1);
`endif

        check("dclk_while_cs_high", dclk_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
